// File: rtl/usb_pkg.sv
// Shared constants, FSM state type and the CRC5 byte-update helper for the
// USB token receive path.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;

  typedef enum logic [2:0] {
    IDLE,
    B1,
    B2,
    WAIT_EOP,
    SKIP
  } state_t;

  // Advance the CRC5 (x^5+x^2+1) by one byte, bit 0 first as on the wire.
  function automatic logic [4:0] crc5_byte_next(input logic [4:0] crc_in,
                                                input logic [7:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[4] ^ data[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ CRC5_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc5_byte.sv
// Byte-parallel CRC5 register: preset by init, advanced one byte per en.
module usb_crc5_byte
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic [4:0] crc
);

  // CRC state: preset wins over update so a new token always starts clean.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC5_INIT;
    end else if (en) begin
      crc <= crc5_byte_next(crc, data);
    end
  end

endmodule

// File: rtl/usb_token_rx.sv
// USB token decoder: collects PID + two token bytes from the deserializer,
// checks PID, length and CRC5, and emits a registered one-cycle result pulse.
module usb_token_rx
  import usb_pkg::*;
#(
  parameter bit DEV_ADDR_CHECK = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  input  logic       rx_err,
  input  logic [6:0] dev_addr,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       crc_err,
  output logic       pid_err,
  output logic       len_err,
  output logic       busy
);

  state_t     state, state_nx;
  logic [3:0] pid_q;
  logic [7:0] byte1_q;
  logic [2:0] endp_hi_q;
  logic [4:0] crc;
  logic       crc_init, crc_en;
  logic       pid_ld, b1_ld, b2_ld;
  logic       tok_valid_d, crc_err_d, pid_err_d, len_err_d;
  logic       pid_ok, is_token, addr_match;

  assign pid_ok     = (rx_data[7:4] == ~rx_data[3:0]);
  assign is_token   = pid_ok && (rx_data[3:0] inside {PID_OUT, PID_IN, PID_SOF, PID_SETUP});
  // SOF carries a frame number, not an address, so it is never filtered.
  assign addr_match = !DEV_ADDR_CHECK || (pid_q == PID_SOF) || (byte1_q[6:0] == dev_addr);
  assign busy       = (state != IDLE);

  usb_crc5_byte u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (rx_data),
    .crc  (crc)
  );

  // Next-state and result decode; rx_err outranks rx_eop outside IDLE.
  always_comb begin
    state_nx    = state;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    pid_ld      = 1'b0;
    b1_ld       = 1'b0;
    b2_ld       = 1'b0;
    tok_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    pid_err_d   = 1'b0;
    len_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (!pid_ok) begin
            pid_err_d = 1'b1;
            state_nx  = SKIP;
          end else if (is_token) begin
            pid_ld   = 1'b1;
            crc_init = 1'b1;
            state_nx = B1;
          end else begin
            state_nx = SKIP;
          end
        end
      end
      B1: begin
        if (rx_err) begin
          state_nx = IDLE;
        end else if (rx_valid) begin
          crc_en   = 1'b1;
          b1_ld    = 1'b1;
          state_nx = B2;
        end else if (rx_eop) begin
          len_err_d = 1'b1;
          state_nx  = IDLE;
        end
      end
      B2: begin
        if (rx_err) begin
          state_nx = IDLE;
        end else if (rx_valid) begin
          crc_en   = 1'b1;
          b2_ld    = 1'b1;
          state_nx = WAIT_EOP;
        end else if (rx_eop) begin
          len_err_d = 1'b1;
          state_nx  = IDLE;
        end
      end
      WAIT_EOP: begin
        if (rx_err) begin
          state_nx = IDLE;
        end else if (rx_valid) begin
          len_err_d = 1'b1;
          state_nx  = SKIP;
        end else if (rx_eop) begin
          state_nx = IDLE;
          if (crc == CRC5_RESIDUAL) tok_valid_d = addr_match;
          else                      crc_err_d   = 1'b1;
        end
      end
      SKIP: begin
        if (rx_err || rx_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tok_valid <= 1'b0;
      crc_err   <= 1'b0;
      pid_err   <= 1'b0;
      len_err   <= 1'b0;
      tok_pid   <= 4'h0;
      tok_addr  <= 7'h0;
      tok_endp  <= 4'h0;
    end else begin
      state     <= state_nx;
      tok_valid <= tok_valid_d;
      crc_err   <= crc_err_d;
      pid_err   <= pid_err_d;
      len_err   <= len_err_d;
      if (tok_valid_d) begin
        tok_pid  <= pid_q;
        tok_addr <= byte1_q[6:0];
        tok_endp <= {endp_hi_q, byte1_q[7]};
      end
    end
  end

  // Packet field capture; only meaningful once the FSM has walked past it.
  always_ff @(posedge clk) begin
    if (pid_ld) pid_q     <= rx_data[3:0];
    if (b1_ld)  byte1_q   <= rx_data;
    if (b2_ld)  endp_hi_q <= rx_data[2:0];
  end

endmodule
